alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that runs unsigned multiply and restoring divide through an external WIDTH-bit ALU.
- The ALU is a rippled chain of part_74S181 slices; this block drives its function select, mode, carry-in and operands, and samples F and COUT_N each step.
- Holds the accumulator/quotient registers and a step counter.
- Sits beside the main datapath ALU and borrows its function port for the duration of an operation.

---
 rtl/alu_muldiv_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Multi-cycle unsigned multiply / restoring divide sequencer. It owns no
//   adder of its own. Every step goes through an external WIDTH-bit ALU built
//   from rippled 74S181 slices, which this block borrows from the main
//   datapath while an operation runs.
//
//   Multiply (op=0): shift-and-add, LSB of the multiplier first.
//     res_hi:res_lo = opa * opb
//   Divide   (op=1): restoring divide, one quotient bit per step.
//     res_lo = opa / opb, res_hi = opa % opb
//     opb==0 is not special-cased. It yields res_lo=all ones, res_hi=opa and
//     raises div0.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start, op         start request (sampled only in IDLE), 0=mul 1=div
//   opa, opb          multiplicand/dividend, multiplier/divisor
//   busy, done        busy in STEP and DONE; done is a one-cycle result pulse
//   div0              divide-by-zero flag, held until the next accepted start
//   res_hi, res_lo    ACC register (product high / remainder),
//                     Q register (product low / quotient)
//   alu_a, alu_b      ALU operands
//   alu_s, alu_m      ALU function select and mode
//   alu_cin_n         ALU carry-in, active-low
//   alu_f, alu_cout_n ALU result and carry-out (active-low), same cycle
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin_n,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout_n
);

  // 74S181 arithmetic-mode encodings
  localparam logic [3:0] S_PASS = 4'b0000;  // F = A        (cin_n = 1)
  localparam logic [3:0] S_ADD  = 4'b1001;  // F = A + B    (cin_n = 1)
  localparam logic [3:0] S_SUB  = 4'b0110;  // F = A - B    (cin_n = 0)

  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  acc,    acc_nxt;
  logic [WIDTH-1:0]  quo,    quo_nxt;
  logic [WIDTH-1:0]  b_reg,  b_nxt;
  logic [CNTW-1:0]   count,  count_nxt;
  logic              op_reg, op_nxt;
  logic              div0_reg, div0_nxt;

  logic              mul_carry;
  logic              div_ok;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      quo      <= '0;
      b_reg    <= '0;
      count    <= '0;
      op_reg   <= 1'b0;
      div0_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      quo      <= quo_nxt;
      b_reg    <= b_nxt;
      count    <= count_nxt;
      op_reg   <= op_nxt;
      div0_reg <= div0_nxt;
    end
  end

  // Next state, register updates and ALU control
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    quo_nxt   = quo;
    b_nxt     = b_reg;
    count_nxt = count;
    op_nxt    = op_reg;
    div0_nxt  = div0_reg;
    alu_a     = acc;
    alu_s     = S_PASS;
    alu_cin_n = 1'b1;
    mul_carry = 1'b0;
    div_ok    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          op_nxt    = op;
          b_nxt     = opb;
          acc_nxt   = '0;
          quo_nxt   = opa;
          count_nxt = '0;
          div0_nxt  = op & (opb == '0);
          state_nxt = STEP;
        end
      end

      STEP: begin
        if (!op_reg) begin
          // Add the multiplicand only when the current multiplier bit is set,
          // then shift ACC:Q right one place, the carry landing in ACC's MSB.
          if (quo[0]) begin
            alu_s     = S_ADD;
            mul_carry = ~alu_cout_n;
          end
          acc_nxt = {mul_carry, alu_f[WIDTH-1:1]};
          quo_nxt = {alu_f[0], quo[WIDTH-1:1]};
        end else begin
          // Trial subtract of the divisor from the partial remainder shifted
          // left by one. A set ACC MSB means the shifted value has a 33rd bit,
          // so it exceeds any divisor regardless of the ALU borrow.
          alu_a     = {acc[WIDTH-2:0], quo[WIDTH-1]};
          alu_s     = S_SUB;
          alu_cin_n = 1'b0;
          div_ok    = ~alu_cout_n | acc[WIDTH-1];
          acc_nxt   = div_ok ? alu_f : alu_a;
          quo_nxt   = {quo[WIDTH-2:0], div_ok};
        end
        count_nxt = count + 1'b1;
        if (count == LAST_STEP) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign alu_b  = b_reg;
  assign alu_m  = 1'b0;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign div0   = div0_reg;
  assign res_hi = acc;
  assign res_lo = quo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          op;
  logic [W-1:0]  opa, opb;
  logic          busy, done, div0;
  logic [W-1:0]  res_hi, res_lo;
  logic [W-1:0]  alu_a, alu_b, alu_f;
  logic [3:0]    alu_s;
  logic          alu_m, alu_cin_n, alu_cout_n;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv_seq #(.WIDTH(W), .CNTW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .div0       (div0),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_cin_n  (alu_cin_n),
    .alu_f      (alu_f),
    .alu_cout_n (alu_cout_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural W-bit 74S181 chain (active-high data). Returns {cout_n, F}.
  function automatic logic [W:0] alu181(input logic [3:0] s, input logic m,
                                        input logic cin_n,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   x, y, sum;
    logic [W-1:0] f;
    x = {1'b0, a};
    y = '0;
    f = '0;
    if (m) begin
      case (s)
        4'h0: f = ~a;        4'h1: f = ~(a | b);
        4'h2: f = ~a & b;    4'h3: f = '0;
        4'h4: f = ~(a & b);  4'h5: f = ~b;
        4'h6: f = a ^ b;     4'h7: f = a & ~b;
        4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);
        4'hA: f = b;         4'hB: f = a & b;
        4'hC: f = '1;        4'hD: f = a | ~b;
        4'hE: f = a | b;     default: f = a;
      endcase
      return {1'b1, f};
    end
    case (s)
      4'h0: y = '0;
      4'h1: x = {1'b0, a | b};
      4'h2: x = {1'b0, a | ~b};
      4'h3: x = {1'b0, {W{1'b1}}};
      4'h4: y = {1'b0, a & ~b};
      4'h5: begin x = {1'b0, a | b};  y = {1'b0, a & ~b}; end
      4'h6: y = {1'b0, ~b};
      4'h7: begin x = {1'b0, a & ~b}; y = {1'b0, {W{1'b1}}}; end
      4'h8: y = {1'b0, a & b};
      4'h9: y = {1'b0, b};
      4'hA: begin x = {1'b0, a | ~b}; y = {1'b0, a & b}; end
      4'hB: begin x = {1'b0, a & b};  y = {1'b0, {W{1'b1}}}; end
      4'hC: y = {1'b0, a};
      4'hD: begin x = {1'b0, a | b};  y = {1'b0, a}; end
      4'hE: begin x = {1'b0, a | ~b}; y = {1'b0, a}; end
      default: y = {1'b0, {W{1'b1}}};
    endcase
    sum = x + y + {{W{1'b0}}, ~cin_n};
    return {~sum[W], sum[W-1:0]};
  endfunction

  always_comb {alu_cout_n, alu_f} = alu181(alu_s, alu_m, alu_cin_n, alu_a, alu_b);

  // Reference: plain arithmetic. Returns {div0, hi, lo}.
  function automatic logic [2*W:0] ref_model(input logic o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (!o) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    return {1'b0, a % b, a / b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ALU must be left in PASS of ACC whenever the block is not busy,
  // and done must never appear without busy.
  always @(negedge clk) begin
    if (!busy) begin
      chk("idle_alu_ctl", {58'd0, alu_s, alu_m, alu_cin_n}, {58'd0, 4'b0000, 1'b0, 1'b1});
      chk("idle_alu_a", {32'd0, alu_a}, {32'd0, res_hi});
    end
    chk("done_wo_busy", {63'd0, done & ~busy}, 64'd0);
  end

  // One operation from an idle start; poke>=0 pulses start (with other
  // operands) during the step phase, which must be ignored.
  task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                       input int poke);
    int lat;
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; opa = $urandom; opb = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      start = (lat == poke);
      @(posedge clk); #1;
      lat++;
      if (lat == 5) chk("busy_step", {63'd0, busy}, 64'd1);
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(W));
    chk("res_hi", {32'd0, res_hi}, {32'd0, eh});
    chk("res_lo", {32'd0, res_lo}, {32'd0, el});
    chk("div0", {63'd0, div0}, {63'd0, ed});
    chk("busy_done", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("hold_hi", {32'd0, res_hi}, {32'd0, eh});
    chk("hold_lo", {32'd0, res_lo}, {32'd0, el});
    chk("hold_div0", {63'd0, div0}, {63'd0, ed});
  endtask

  typedef struct {
    logic         o;
    logic [W-1:0] a, b;
    logic [W-1:0] eh, el;
    logic         ed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [2*W:0] r;
    logic         ro;
    logic [W-1:0] ra, rb;
    logic         seen;

    tbl[0] = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0};
    tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[4] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[6] = '{1'b1, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    #12;
    chk("rst_res_hi", {32'd0, res_hi}, 64'd0);
    chk("rst_res_lo", {32'd0, res_lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div0}, 64'd0);
    chk("rst_alu_ctl", {58'd0, alu_s, alu_m, alu_cin_n}, {58'd0, 6'b000001});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].ed, -1);

    // start pulsed mid-operation with other operands is ignored
    do_op(1'b0, 32'd7, 32'd6, 32'd0, 32'h2A, 1'b0, 5);
    do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 20);

    // asynchronous reset during step 10 of a divide-by-zero
    op = 1'b1; opa = 32'h55; opb = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_abort_div0", {63'd0, div0}, 64'd1);
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_flags", {61'd0, busy, done, div0}, 64'd0);
    chk("abort_res", {res_hi, res_lo}, 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (37) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    r = ref_model(1'b0, 32'd1234, 32'd5678);
    do_op(1'b0, 32'd1234, 32'd5678, r[2*W-1:W], r[W-1:0], r[2*W], -1);

    // randomized operations against the arithmetic reference
    for (int k = 0; k < 50; k++) begin
      int sel;
      ro  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = W'($urandom_range(1, 15));
      else if (sel == 2) rb = $urandom | 32'h8000_0000;
      else               rb = $urandom;
      r = ref_model(ro, ra, rb);
      do_op(ro, ra, rb, r[2*W-1:W], r[W-1:0], r[2*W],
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
